// File: rtl/video_pkg.sv
// Shared constants and types for the SDLoad text display video path.
// Holds default VGA 640x480 timing, character cell geometry and fetch-stage memory layout.
package video_pkg;

  localparam int CNT_W = 11;

  localparam int H_ACT_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_ACT_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  localparam int CHAR_W_DEF = 8;
  localparam int CHAR_H_DEF = 16;

  localparam int CHAR_BASE   = 32'h0000_0000;
  localparam int ATTR_BASE   = 32'h0000_1000;
  localparam int CHAR_STRIDE = 80;
  localparam int ATTR_STRIDE = 80;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       hpix;
    logic       vpix;
    logic       v_init;
    logic       h_init;
    logic       h_step;
    logic       h_char;
    logic [3:0] char_row;
  } sync_out_t;

  function automatic logic in_range(input cnt_t x, input cnt_t lo, input cnt_t hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/video_sync_if.sv
// Raster timing bundle from video_sync to the character/attribute fetch stage.
interface video_sync_if;
  logic       pix_stb;
  logic       o_hsync;
  logic       o_vsync;
  logic       o_hpix;
  logic       o_vpix;
  logic       v_init;
  logic       h_init;
  logic       h_step;
  logic       h_char;
  logic [3:0] char_row;

  modport master (output pix_stb, o_hsync, o_vsync, o_hpix, o_vpix,
                         v_init, h_init, h_step, h_char, char_row);
  modport slave  (input  pix_stb, o_hsync, o_vsync, o_hpix, o_vpix,
                         v_init, h_init, h_step, h_char, char_row);
endinterface

// File: rtl/video_sync_axis.sv
// One raster axis: position counter plus active/sync decode of the current count.
// The counter advances when both tick and wrap_in are set; wrap flags the final position.
module video_sync_axis
  import video_pkg::*;
#(
  parameter int ACT  = H_ACT_DEF,
  parameter int FP   = H_FP_DEF,
  parameter int SYNC = H_SYNC_DEF,
  parameter int BP   = H_BP_DEF,
  parameter bit POL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic wrap_in,
  output cnt_t count,
  output logic active,
  output logic sync,
  output logic wrap
);

  localparam int TOT = ACT + FP + SYNC + BP;

  cnt_t count_q;
  cnt_t count_d;

  always_comb begin
    wrap    = tick && wrap_in && (count_q == cnt_t'(TOT - 1));
    count_d = count_q;
    if (tick && wrap_in) begin
      count_d = wrap ? '0 : count_q + cnt_t'(1);
    end
    active = (count_q < cnt_t'(ACT));
    sync   = in_range(count_q, cnt_t'(ACT + FP), cnt_t'(ACT + FP + SYNC)) ? POL : ~POL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/video_sync.sv
// Raster timing generator: pixel-rate divider, h/v/row counters and registered decode.
// Outputs load the decode of the current position on each tick, so every pix_stb sees one position.
module video_sync
  import video_pkg::*;
#(
  parameter int PIX_DIV = 2,
  parameter int H_ACT   = H_ACT_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_ACT   = V_ACT_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF,
  parameter int CHAR_W  = CHAR_W_DEF,
  parameter int CHAR_H  = CHAR_H_DEF,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  video_sync_if.master vid
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

  cnt_t       div_q, div_d;
  logic       pix_stb_q, pix_stb_d;
  logic [3:0] row_q, row_d;
  sync_out_t  out_q, out_d;
  logic       tick;

  cnt_t h_cnt, v_cnt;
  logic h_act, h_sync, h_wrap;
  logic v_act, v_sync, v_wrap;

  video_sync_axis #(.ACT(H_ACT), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)) u_h (
    .clk(clk), .rst(rst), .tick(tick), .wrap_in(1'b1),
    .count(h_cnt), .active(h_act), .sync(h_sync), .wrap(h_wrap)
  );

  video_sync_axis #(.ACT(V_ACT), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)) u_v (
    .clk(clk), .rst(rst), .tick(tick), .wrap_in(h_wrap),
    .count(v_cnt), .active(v_act), .sync(v_sync), .wrap(v_wrap)
  );

  always_comb begin
    tick      = (div_q == cnt_t'(PIX_DIV - 1));
    div_d     = tick ? '0 : div_q + cnt_t'(1);
    pix_stb_d = tick;

    // Row only counts inside the active frame and restarts with every new frame.
    row_d = row_q;
    if (v_wrap) begin
      row_d = 4'd0;
    end else if (h_wrap && v_act) begin
      row_d = (row_q == 4'(CHAR_H - 1)) ? 4'd0 : row_q + 4'd1;
    end

    out_d = out_q;
    if (tick) begin
      out_d.hsync    = h_sync;
      out_d.vsync    = v_sync;
      out_d.hpix     = h_act;
      out_d.vpix     = v_act;
      out_d.h_char   = h_act && ((h_cnt & cnt_t'(CHAR_W - 1)) == cnt_t'(CHAR_W - 1));
      out_d.h_init   = (h_cnt == cnt_t'(H_TOT - 1));
      out_d.h_step   = (h_cnt == cnt_t'(H_ACT)) && v_act && (row_q == 4'(CHAR_H - 1));
      out_d.v_init   = (h_cnt == cnt_t'(H_ACT)) && (v_cnt == cnt_t'(V_TOT - 1));
      out_d.char_row = row_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q          <= '0;
      pix_stb_q      <= 1'b0;
      row_q          <= 4'd0;
      out_q          <= '0;
      out_q.hsync    <= ~HS_POL;
      out_q.vsync    <= ~VS_POL;
    end else begin
      div_q          <= div_d;
      pix_stb_q      <= pix_stb_d;
      row_q          <= row_d;
      out_q          <= out_d;
    end
  end

  assign vid.pix_stb  = pix_stb_q;
  assign vid.o_hsync  = out_q.hsync;
  assign vid.o_vsync  = out_q.vsync;
  assign vid.o_hpix   = out_q.hpix;
  assign vid.o_vpix   = out_q.vpix;
  assign vid.v_init   = out_q.v_init;
  assign vid.h_init   = out_q.h_init;
  assign vid.h_step   = out_q.h_step;
  assign vid.h_char   = out_q.h_char;
  assign vid.char_row = out_q.char_row;

endmodule
